dsp_mac_pipe: RTL



---
 rtl/dsp_mac_pipe_pkg.sv | 32 +++
 rtl/dsp_mac_pipe_if.sv | 38 +++
 rtl/dsp_pipe_reg.sv | 17 +
 rtl/dsp_mac_pipe.sv | 130 +++++++++++++
 4 files changed

// File: rtl/dsp_mac_pipe_pkg.sv
// Shared constants for the DSP MAC slice: OPMODE bit positions, X/Z mux
// select codes and the control bundle forwarded to the post-add stage.
package dsp_pkg;

    // OPMODE bit positions
    localparam int OP_X_LSB    = 0;  // [1:0] X mux select
    localparam int OP_Z_LSB    = 2;  // [3:2] Z mux select
    localparam int OP_USE_PRE  = 4;  // multiplier takes pre-adder output
    localparam int OP_CIN_EN   = 5;  // carry-in enable
    localparam int OP_PRE_SUB  = 6;  // pre-adder D-B instead of D+B
    localparam int OP_POST_SUB = 7;  // post-adder Z-(X+CIN)

    // X mux selects
    localparam logic [1:0] X_ZERO = 2'd0;
    localparam logic [1:0] X_M    = 2'd1;
    localparam logic [1:0] X_P    = 2'd2;
    localparam logic [1:0] X_DAB  = 2'd3;

    // Z mux selects
    localparam logic [1:0] Z_ZERO = 2'd0;
    localparam logic [1:0] Z_PCIN = 2'd1;
    localparam logic [1:0] Z_P    = 2'd2;
    localparam logic [1:0] Z_C    = 2'd3;

    // OPMODE fields still needed once the multiply is done
    typedef struct packed {
        logic       post_sub;
        logic [1:0] z_sel;
        logic [1:0] x_sel;
    } post_ctl_t;

endpackage

// File: rtl/dsp_mac_pipe_if.sv
// Operand/result bundle of the DSP MAC slice. master drives operands,
// slave is the slice itself.
interface dsp_mac_pipe_if #(
    parameter int A_W = 18,
    parameter int B_W = 18,
    parameter int C_W = 48,
    parameter int P_W = 48
);
    localparam int M_W = A_W + B_W + 1;

    logic           CE;
    logic           in_valid;
    logic [A_W-1:0] A;
    logic [B_W-1:0] B;
    logic [B_W-1:0] D;
    logic [C_W-1:0] C;
    logic [P_W-1:0] PCIN;
    logic           CARRYIN;
    logic [7:0]     OPMODE;

    logic           out_valid;
    logic [P_W-1:0] P;
    logic [P_W-1:0] PCOUT;
    logic [M_W-1:0] M;
    logic           CARRYOUT;
    logic           OVERFLOW;
    logic           PATTERN_DETECT;

    modport master (
        output CE, in_valid, A, B, D, C, PCIN, CARRYIN, OPMODE,
        input  out_valid, P, PCOUT, M, CARRYOUT, OVERFLOW, PATTERN_DETECT
    );

    modport slave (
        input  CE, in_valid, A, B, D, C, PCIN, CARRYIN, OPMODE,
        output out_valid, P, PCOUT, M, CARRYOUT, OVERFLOW, PATTERN_DETECT
    );
endinterface

// File: rtl/dsp_pipe_reg.sv
// Generic pipeline register with global clock enable and async clear.
module dsp_pipe_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // Capture d on enabled edges; clear immediately on reset
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
        if (!rst_n)  q <= '0;
        else if (ce) q <= d;
    end
endmodule

// File: rtl/dsp_mac_pipe.sv
// Three-stage pre-add / multiply / post-add slice with valid tracking,
// global stall, optional saturation, overflow/carry flags and pattern detect.
module dsp_mac_pipe
    import dsp_pkg::*;
#(
    parameter int             A_W     = 18,
    parameter int             B_W     = 18,
    parameter int             C_W     = 48,
    parameter int             P_W     = 48,
    parameter bit             SAT_EN  = 1'b0,
    parameter logic [P_W-1:0] PATTERN = '0,
    parameter logic [P_W-1:0] MASK    = '0
) (
    input logic           clk,
    input logic           RST_N,
    dsp_mac_pipe_if.slave bus
);
    localparam int M_W   = A_W + B_W + 1;
    localparam int CTL_W = $bits(post_ctl_t);

    // ---------------- stage 1: operand capture ----------------
    logic signed [A_W-1:0] a1;
    logic signed [B_W-1:0] b1, d1;
    logic signed [C_W-1:0] c1;
    logic [P_W-1:0]        pcin1;
    logic                  carryin1, v1;
    logic [7:0]            op1;

    dsp_pipe_reg #(.WIDTH(A_W)) u_a1    (.clk(clk), .rst_n(RST_N), .ce(bus.CE), .d(bus.A),        .q(a1));
    dsp_pipe_reg #(.WIDTH(B_W)) u_b1    (.clk(clk), .rst_n(RST_N), .ce(bus.CE), .d(bus.B),        .q(b1));
    dsp_pipe_reg #(.WIDTH(B_W)) u_d1    (.clk(clk), .rst_n(RST_N), .ce(bus.CE), .d(bus.D),        .q(d1));
    dsp_pipe_reg #(.WIDTH(C_W)) u_c1    (.clk(clk), .rst_n(RST_N), .ce(bus.CE), .d(bus.C),        .q(c1));
    dsp_pipe_reg #(.WIDTH(P_W)) u_pcin1 (.clk(clk), .rst_n(RST_N), .ce(bus.CE), .d(bus.PCIN),     .q(pcin1));
    dsp_pipe_reg #(.WIDTH(1))   u_cy1   (.clk(clk), .rst_n(RST_N), .ce(bus.CE), .d(bus.CARRYIN),  .q(carryin1));
    dsp_pipe_reg #(.WIDTH(8))   u_op1   (.clk(clk), .rst_n(RST_N), .ce(bus.CE), .d(bus.OPMODE),   .q(op1));
    dsp_pipe_reg #(.WIDTH(1))   u_v1    (.clk(clk), .rst_n(RST_N), .ce(bus.CE), .d(bus.in_valid), .q(v1));

    // ---------------- stage 2: pre-add and multiply ----------------
    logic signed [B_W:0]   pre_sum, mult_b;
    logic signed [M_W-1:0] m_next;
    logic                  cin_next;
    post_ctl_t             ctl_next;

    // Full-precision pre-adder feeding a never-truncated signed multiply
    always_comb begin
        pre_sum  = op1[OP_PRE_SUB] ? ((B_W+1)'(d1) - (B_W+1)'(b1))
                                   : ((B_W+1)'(d1) + (B_W+1)'(b1));
        mult_b   = op1[OP_USE_PRE] ? pre_sum : (B_W+1)'(b1);
        m_next   = M_W'(a1) * M_W'(mult_b);
        cin_next = op1[OP_CIN_EN] & carryin1;
        ctl_next = '{post_sub: op1[OP_POST_SUB],
                     z_sel:    op1[OP_Z_LSB +: 2],
                     x_sel:    op1[OP_X_LSB +: 2]};
    end

    logic signed [M_W-1:0] m2;
    logic signed [A_W-1:0] a2;
    logic signed [B_W-1:0] b2, d2;
    logic signed [C_W-1:0] c2;
    logic [P_W-1:0]        pcin2;
    logic                  cin2, v2;
    post_ctl_t             ctl2;

    dsp_pipe_reg #(.WIDTH(M_W))   u_m2    (.clk(clk), .rst_n(RST_N), .ce(bus.CE), .d(m_next),   .q(m2));
    dsp_pipe_reg #(.WIDTH(A_W))   u_a2    (.clk(clk), .rst_n(RST_N), .ce(bus.CE), .d(a1),       .q(a2));
    dsp_pipe_reg #(.WIDTH(B_W))   u_b2    (.clk(clk), .rst_n(RST_N), .ce(bus.CE), .d(b1),       .q(b2));
    dsp_pipe_reg #(.WIDTH(B_W))   u_d2    (.clk(clk), .rst_n(RST_N), .ce(bus.CE), .d(d1),       .q(d2));
    dsp_pipe_reg #(.WIDTH(C_W))   u_c2    (.clk(clk), .rst_n(RST_N), .ce(bus.CE), .d(c1),       .q(c2));
    dsp_pipe_reg #(.WIDTH(P_W))   u_pcin2 (.clk(clk), .rst_n(RST_N), .ce(bus.CE), .d(pcin1),    .q(pcin2));
    dsp_pipe_reg #(.WIDTH(1))     u_cin2  (.clk(clk), .rst_n(RST_N), .ce(bus.CE), .d(cin_next), .q(cin2));
    dsp_pipe_reg #(.WIDTH(CTL_W)) u_ctl2  (.clk(clk), .rst_n(RST_N), .ce(bus.CE), .d(ctl_next), .q(ctl2));
    dsp_pipe_reg #(.WIDTH(1))     u_v2    (.clk(clk), .rst_n(RST_N), .ce(bus.CE), .d(v1),       .q(v2));

    // ---------------- stage 3: post-add, flags, saturation ----------------
    logic [P_W-1:0]        p3;
    logic signed [P_W-1:0] x_val, z_val;
    logic signed [P_W:0]   x_plus_cin, true_sum;
    logic                  ovf_next, carry_next;
    logic [P_W-1:0]        p_next;

    // Muxes read the live P register so accumulation runs every cycle
    always_comb begin
        // NOTE: every output gets a value before the case so no latch is inferred.
        x_val = '0;
        z_val = '0;
        case (ctl2.x_sel)
            X_M:     x_val = P_W'(m2);
            X_P:     x_val = p3;
            X_DAB:   x_val = P_W'({d2, a2, b2});
            default: x_val = '0;
        endcase
        case (ctl2.z_sel)
            Z_PCIN:  z_val = pcin2;
            Z_P:     z_val = p3;
            Z_C:     z_val = P_W'(c2);
            default: z_val = '0;
        endcase

        // One extra bit holds the exact signed result of every mux combination
        x_plus_cin = (P_W+1)'(x_val) + (P_W+1)'({1'b0, cin2});
        true_sum   = ctl2.post_sub ? ((P_W+1)'(z_val) - x_plus_cin)
                                   : ((P_W+1)'(z_val) + x_plus_cin);
        ovf_next   = true_sum[P_W] ^ true_sum[P_W-1];
        // Zero-extended operands differ from sign-extended ones only by their
        // sign bits at weight 2^P_W, so the unsigned carry is a parity of those;
        // for subtract the borrow is inverted.
        carry_next = true_sum[P_W] ^ z_val[P_W-1] ^ x_val[P_W-1] ^ ctl2.post_sub;

        p_next = true_sum[P_W-1:0];
        if (SAT_EN && ovf_next) begin
            p_next = true_sum[P_W] ? {1'b1, {(P_W-1){1'b0}}} : {1'b0, {(P_W-1){1'b1}}};
        end
    end

    logic carry3, ovf3, v3;

    dsp_pipe_reg #(.WIDTH(P_W)) u_p3   (.clk(clk), .rst_n(RST_N), .ce(bus.CE), .d(p_next),     .q(p3));
    dsp_pipe_reg #(.WIDTH(1))   u_cy3  (.clk(clk), .rst_n(RST_N), .ce(bus.CE), .d(carry_next), .q(carry3));
    dsp_pipe_reg #(.WIDTH(1))   u_ovf3 (.clk(clk), .rst_n(RST_N), .ce(bus.CE), .d(ovf_next),   .q(ovf3));
    dsp_pipe_reg #(.WIDTH(1))   u_v3   (.clk(clk), .rst_n(RST_N), .ce(bus.CE), .d(v2),         .q(v3));

    assign bus.P              = p3;
    assign bus.PCOUT          = p3;
    assign bus.M              = m2;
    assign bus.CARRYOUT       = carry3;
    assign bus.OVERFLOW       = ovf3;
    assign bus.out_valid      = v3;
    assign bus.PATTERN_DETECT = (((p3 ^ PATTERN) & ~MASK) == '0);

endmodule
